// File: rtl/mips_pkg.sv
// Shared MIPS encodings: opcodes, funct codes, ALU operation codes and control FSM states.
// Imported by the control FSM, the funct decoder, the ALU and the datapath.
package mips_pkg;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_J     = 6'b000010;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;

  localparam logic [5:0] FN_ADD = 6'b100000;
  localparam logic [5:0] FN_SUB = 6'b100010;
  localparam logic [5:0] FN_AND = 6'b100100;
  localparam logic [5:0] FN_OR  = 6'b100101;
  localparam logic [5:0] FN_SLT = 6'b101010;

  localparam logic [3:0] ALU_AND = 4'd0;
  localparam logic [3:0] ALU_OR  = 4'd1;
  localparam logic [3:0] ALU_ADD = 4'd2;
  localparam logic [3:0] ALU_SUB = 4'd6;
  localparam logic [3:0] ALU_SLT = 4'd7;

  localparam logic [1:0] SRCB_B      = 2'b00;
  localparam logic [1:0] SRCB_FOUR   = 2'b01;
  localparam logic [1:0] SRCB_IMM    = 2'b10;
  localparam logic [1:0] SRCB_IMM_SH = 2'b11;

  localparam logic [1:0] PCSRC_ALU    = 2'b00;
  localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
  localparam logic [1:0] PCSRC_JUMP   = 2'b10;

  typedef enum logic [3:0] {
    S_FETCH   = 4'd0,
    S_DECODE  = 4'd1,
    S_MEMADR  = 4'd2,
    S_MEMRD   = 4'd3,
    S_MEMWB   = 4'd4,
    S_MEMWR   = 4'd5,
    S_RTYPEEX = 4'd6,
    S_RTYPEWB = 4'd7,
    S_BEQEX   = 4'd8,
    S_ADDIEX  = 4'd9,
    S_ADDIWB  = 4'd10,
    S_JEX     = 4'd11
  } state_t;

  // Moore control word decoded from the state register.
  typedef struct packed {
    logic [3:0] alu_ctrl;
    logic       src_a;
    logic [1:0] src_b;
    logic [1:0] pc_source;
    logic       pc_write;
    logic       branch;
    logic       iord;
    logic       mem_write;
    logic       ir_write;
    logic       reg_dst;
    logic       mem_to_reg;
    logic       reg_write;
  } ctrl_t;

  function automatic ctrl_t ctrl_idle();
    ctrl_t c;
    c          = '0;
    c.alu_ctrl = ALU_ADD;
    return c;
  endfunction

  function automatic logic op_supported(input logic [5:0] op);
    return op inside {OP_RTYPE, OP_J, OP_BEQ, OP_ADDI, OP_LW, OP_SW};
  endfunction

endpackage

// File: rtl/mips_funct_decode.sv
// Combinational R-type funct -> ALU operation map; flags functs the datapath cannot execute.
// Unsupported functs yield ALU_ADD so the ALU input stays benign.
module mips_funct_decode
  import mips_pkg::*;
(
  input  logic [5:0] funct_i,
  output logic [3:0] alu_ctrl_o,
  output logic       illegal_o
);

  always_comb begin
    alu_ctrl_o = ALU_ADD;
    illegal_o  = 1'b0;
    case (funct_i)
      FN_ADD:  alu_ctrl_o = ALU_ADD;
      FN_SUB:  alu_ctrl_o = ALU_SUB;
      FN_AND:  alu_ctrl_o = ALU_AND;
      FN_OR:   alu_ctrl_o = ALU_OR;
      FN_SLT:  alu_ctrl_o = ALU_SLT;
      default: illegal_o  = 1'b1;
    endcase
  end

endmodule

// File: rtl/mips_multicycle_control.sv
// Main control FSM of the multicycle MIPS datapath: Moore control word per state,
// except PC_en which also admits the branch-taken term from ALU_zero in BEQEX.
module mips_multicycle_control
  import mips_pkg::*;
#(
  parameter int ALU_CTRL_W = 4,
  parameter int STATE_W    = 4
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic [5:0]            opcode,
  input  logic [5:0]            funct,
  input  logic                  ALU_zero,
  output logic [ALU_CTRL_W-1:0] ALU_control,
  output logic                  ALU_src_A,
  output logic [1:0]            ALU_src_B,
  output logic [1:0]            PC_source,
  output logic                  PC_en,
  output logic                  IorD,
  output logic                  mem_write,
  output logic                  IR_write,
  output logic                  reg_dst,
  output logic                  mem_to_reg,
  output logic                  reg_write,
  output logic                  illegal_op,
  output logic [STATE_W-1:0]    state
);

  state_t     state_q;
  state_t     state_d;
  ctrl_t      ctrl;
  logic       illegal;
  logic [3:0] fn_alu;
  logic       fn_illegal;

  mips_funct_decode u_funct_decode (
    .funct_i    (funct),
    .alu_ctrl_o (fn_alu),
    .illegal_o  (fn_illegal)
  );

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= S_FETCH;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = S_FETCH;
    case (state_q)
      S_FETCH:  state_d = S_DECODE;
      S_DECODE: begin
        case (opcode)
          OP_LW, OP_SW: state_d = S_MEMADR;
          OP_RTYPE:     state_d = S_RTYPEEX;
          OP_BEQ:       state_d = S_BEQEX;
          OP_ADDI:      state_d = S_ADDIEX;
          OP_J:         state_d = S_JEX;
          default:      state_d = S_FETCH;
        endcase
      end
      S_MEMADR:  state_d = (opcode == OP_LW) ? S_MEMRD : S_MEMWR;
      S_MEMRD:   state_d = S_MEMWB;
      S_RTYPEEX: state_d = fn_illegal ? S_FETCH : S_RTYPEWB;
      S_ADDIEX:  state_d = S_ADDIWB;
      default:   state_d = S_FETCH;
    endcase
  end

  always_comb begin
    ctrl    = ctrl_idle();
    illegal = 1'b0;
    case (state_q)
      S_FETCH: begin
        ctrl.ir_write = 1'b1;
        ctrl.src_b    = SRCB_FOUR;
        ctrl.pc_write = 1'b1;
      end
      S_DECODE: begin
        // Branch target is computed speculatively into ALUOut.
        ctrl.src_b = SRCB_IMM_SH;
        illegal    = !op_supported(opcode);
      end
      S_MEMADR: begin
        ctrl.src_a = 1'b1;
        ctrl.src_b = SRCB_IMM;
      end
      S_MEMRD:  ctrl.iord = 1'b1;
      S_MEMWB: begin
        ctrl.mem_to_reg = 1'b1;
        ctrl.reg_write  = 1'b1;
      end
      S_MEMWR: begin
        ctrl.iord      = 1'b1;
        ctrl.mem_write = 1'b1;
      end
      S_RTYPEEX: begin
        ctrl.src_a    = 1'b1;
        ctrl.src_b    = SRCB_B;
        ctrl.alu_ctrl = fn_alu;
        illegal       = fn_illegal;
      end
      S_RTYPEWB: begin
        ctrl.reg_dst   = 1'b1;
        ctrl.reg_write = 1'b1;
      end
      S_BEQEX: begin
        ctrl.src_a     = 1'b1;
        ctrl.src_b     = SRCB_B;
        ctrl.alu_ctrl  = ALU_SUB;
        ctrl.pc_source = PCSRC_ALUOUT;
        ctrl.branch    = 1'b1;
      end
      S_ADDIEX: begin
        ctrl.src_a = 1'b1;
        ctrl.src_b = SRCB_IMM;
      end
      S_ADDIWB: ctrl.reg_write = 1'b1;
      S_JEX: begin
        ctrl.pc_source = PCSRC_JUMP;
        ctrl.pc_write  = 1'b1;
      end
      default: ;
    endcase
  end

  // Enables are gated by reset_n so an async reset stops all writes immediately.
  assign PC_en       = reset_n & (ctrl.pc_write | (ctrl.branch & ALU_zero));
  assign IR_write    = reset_n & ctrl.ir_write;
  assign mem_write   = reset_n & ctrl.mem_write;
  assign reg_write   = reset_n & ctrl.reg_write;
  assign illegal_op  = reset_n & illegal;
  assign ALU_control = ctrl.alu_ctrl;
  assign ALU_src_A   = ctrl.src_a;
  assign ALU_src_B   = ctrl.src_b;
  assign PC_source   = ctrl.pc_source;
  assign IorD        = ctrl.iord;
  assign reg_dst     = ctrl.reg_dst;
  assign mem_to_reg  = ctrl.mem_to_reg;
  assign state       = state_q;

endmodule

// File: tb/tb_mips_multicycle_control.sv
// Bench for mips_multicycle_control: instruction latency table, per-cycle traces from an
// instruction-level model, async reset corner cases and randomized instruction streams.
module tb_mips_multicycle_control;

  logic       clk = 1'b0;
  logic       reset_n;
  logic [5:0] opcode;
  logic [5:0] funct;
  logic       ALU_zero;
  logic [3:0] ALU_control;
  logic       ALU_src_A;
  logic [1:0] ALU_src_B;
  logic [1:0] PC_source;
  logic       PC_en;
  logic       IorD;
  logic       mem_write;
  logic       IR_write;
  logic       reg_dst;
  logic       mem_to_reg;
  logic       reg_write;
  logic       illegal_op;
  logic [3:0] state;

  int n_cmp  = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  mips_multicycle_control dut (
    .clk         (clk),
    .reset_n     (reset_n),
    .opcode      (opcode),
    .funct       (funct),
    .ALU_zero    (ALU_zero),
    .ALU_control (ALU_control),
    .ALU_src_A   (ALU_src_A),
    .ALU_src_B   (ALU_src_B),
    .PC_source   (PC_source),
    .PC_en       (PC_en),
    .IorD        (IorD),
    .mem_write   (mem_write),
    .IR_write    (IR_write),
    .reg_dst     (reg_dst),
    .mem_to_reg  (mem_to_reg),
    .reg_write   (reg_write),
    .illegal_op  (illegal_op),
    .state       (state)
  );

  typedef struct packed {
    logic [3:0] st;
    logic [3:0] alu;
    logic       sa;
    logic [1:0] sb;
    logic [1:0] pcs;
    logic       pce;
    logic       iord;
    logic       mw;
    logic       irw;
    logic       rd;
    logic       m2r;
    logic       rw;
    logic       ill;
  } exp_t;

  typedef struct {
    string      nm;
    logic [5:0] op;
    logic [5:0] fn;
    int         lat;
    int         last;
  } vec_t;

  exp_t exp_q[$];

  task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] want);
    n_cmp++;
    if (got !== want) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", nm, got, want);
    end
  endtask

  function automatic exp_t rec(input int st);
    exp_t r;
    r     = '0;
    r.st  = st[3:0];
    r.alu = 4'd2;
    return r;
  endfunction

  function automatic exp_t sample();
    exp_t s;
    s.st   = state;
    s.alu  = ALU_control;
    s.sa   = ALU_src_A;
    s.sb   = ALU_src_B;
    s.pcs  = PC_source;
    s.pce  = PC_en;
    s.iord = IorD;
    s.mw   = mem_write;
    s.irw  = IR_write;
    s.rd   = reg_dst;
    s.m2r  = mem_to_reg;
    s.rw   = reg_write;
    s.ill  = illegal_op;
    return s;
  endfunction

  // Expected per-cycle control trace of one instruction, from FETCH to its last cycle.
  function automatic void build(input logic [5:0] op, input logic [5:0] fn);
    exp_t r;
    exp_q.delete();
    r = rec(0); r.sb = 2'b01; r.pce = 1'b1; r.irw = 1'b1; exp_q.push_back(r);
    r = rec(1); r.sb = 2'b11;
    if (!(op inside {6'b100011, 6'b101011, 6'b000000, 6'b000100, 6'b001000, 6'b000010})) begin
      r.ill = 1'b1;
      exp_q.push_back(r);
      return;
    end
    exp_q.push_back(r);
    case (op)
      6'b100011: begin
        r = rec(2); r.sa = 1'b1; r.sb = 2'b10; exp_q.push_back(r);
        r = rec(3); r.iord = 1'b1; exp_q.push_back(r);
        r = rec(4); r.m2r = 1'b1; r.rw = 1'b1; exp_q.push_back(r);
      end
      6'b101011: begin
        r = rec(2); r.sa = 1'b1; r.sb = 2'b10; exp_q.push_back(r);
        r = rec(5); r.iord = 1'b1; r.mw = 1'b1; exp_q.push_back(r);
      end
      6'b000000: begin
        r = rec(6); r.sa = 1'b1;
        case (fn)
          6'b100000: r.alu = 4'd2;
          6'b100010: r.alu = 4'd6;
          6'b100100: r.alu = 4'd0;
          6'b100101: r.alu = 4'd1;
          6'b101010: r.alu = 4'd7;
          default:   r.ill = 1'b1;
        endcase
        exp_q.push_back(r);
        if (!r.ill) begin
          r = rec(7); r.rd = 1'b1; r.rw = 1'b1; exp_q.push_back(r);
        end
      end
      6'b000100: begin
        r = rec(8); r.sa = 1'b1; r.alu = 4'd6; r.pcs = 2'b01; exp_q.push_back(r);
      end
      6'b001000: begin
        r = rec(9); r.sa = 1'b1; r.sb = 2'b10; exp_q.push_back(r);
        r = rec(10); r.rw = 1'b1; exp_q.push_back(r);
      end
      default: begin
        r = rec(11); r.pcs = 2'b10; r.pce = 1'b1; exp_q.push_back(r);
      end
    endcase
  endfunction

  // zmode: 0/1 hold ALU_zero, 2 random per cycle, 3 check every cycle under both values.
  // Starts and ends 2ns after a falling edge with the DUT in FETCH.
  task automatic run_instr(input string nm, input logic [5:0] op, input logic [5:0] fn,
                           input int zmode);
    exp_t e;
    int   nz;
    opcode = op;
    funct  = fn;
    build(op, fn);
    nz = (zmode == 3) ? 2 : 1;
    for (int i = 0; i < exp_q.size(); i++) begin
      for (int z = 0; z < nz; z++) begin
        e = exp_q[i];
        if (zmode == 3)      ALU_zero = z[0];
        else if (zmode == 2) ALU_zero = 1'($urandom_range(0, 1));
        else                 ALU_zero = zmode[0];
        if (e.st == 4'd8) e.pce = ALU_zero;
        #1;
        chk($sformatf("%s cyc%0d z%0b", nm, i, ALU_zero), {11'b0, sample()}, {11'b0, e});
      end
      @(negedge clk); #2;
    end
  endtask

  task automatic measure(input vec_t v);
    int         n;
    logic [3:0] last;
    n      = 0;
    last   = '0;
    opcode = v.op;
    funct  = v.fn;
    ALU_zero = 1'b0;
    #1;
    chk({v.nm, " start state"}, 32'(state), 32'd0);
    do begin
      last = state;
      n++;
      @(negedge clk); #2;
    end while (state != 4'd0 && n < 20);
    chk({v.nm, " latency"}, n, v.lat);
    chk({v.nm, " last state"}, 32'(last), v.last);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "time limit");
  end

  initial begin
    vec_t       vt[10];
    exp_t       e;
    logic [5:0] oplist[6] = '{6'b100011, 6'b101011, 6'b000000, 6'b000100, 6'b001000, 6'b000010};
    logic [5:0] fnlist[5] = '{6'b100000, 6'b100010, 6'b100100, 6'b100101, 6'b101010};
    logic [5:0] op, fn;

    vt[0] = '{"lw",      6'b100011, 6'b000000, 5, 4};
    vt[1] = '{"sw",      6'b101011, 6'b000000, 4, 5};
    vt[2] = '{"add",     6'b000000, 6'b100000, 4, 7};
    vt[3] = '{"slt",     6'b000000, 6'b101010, 4, 7};
    vt[4] = '{"addi",    6'b001000, 6'b000000, 4, 10};
    vt[5] = '{"beq",     6'b000100, 6'b000000, 3, 8};
    vt[6] = '{"j",       6'b000010, 6'b000000, 3, 11};
    vt[7] = '{"badop",   6'b111111, 6'b000000, 2, 1};
    vt[8] = '{"badfn",   6'b000000, 6'b000000, 3, 6};
    vt[9] = '{"badop2",  6'b010101, 6'b100000, 2, 1};

    reset_n  = 1'b0;
    opcode   = 6'b100011;
    funct    = 6'b000000;
    ALU_zero = 1'b1;
    @(negedge clk); @(negedge clk); #2;
    e = rec(0); e.sb = 2'b01;
    chk("reset outputs", {11'b0, sample()}, {11'b0, e});

    reset_n = 1'b1;
    run_instr("first lw", 6'b100011, 6'b000000, 3);

    foreach (vt[i]) measure(vt[i]);

    run_instr("sw",        6'b101011, 6'b000000, 3);
    run_instr("slt",       6'b000000, 6'b101010, 3);
    run_instr("sub",       6'b000000, 6'b100010, 2);
    run_instr("beq z1",    6'b000100, 6'b000000, 1);
    run_instr("beq z0",    6'b000100, 6'b000000, 0);
    run_instr("illegal op",6'b111111, 6'b000000, 3);
    run_instr("illegal fn",6'b000000, 6'b000000, 3);
    run_instr("j",         6'b000010, 6'b000000, 3);
    run_instr("addi",      6'b001000, 6'b000000, 3);

    // Async reset landing between edges while lw is in MEMWB.
    opcode = 6'b100011;
    repeat (4) begin @(negedge clk); #2; end
    chk("pre-reset state", 32'(state), 32'd4);
    chk("pre-reset reg_write", 32'(reg_write), 32'd1);
    #1 reset_n = 1'b0;
    #1;
    chk("rst reg_write drop", 32'(reg_write), 32'd0);
    chk("rst state", 32'(state), 32'd0);
    chk("rst PC_en", 32'(PC_en), 32'd0);
    chk("rst IR_write", 32'(IR_write), 32'd0);
    @(negedge clk); #2;
    chk("rst held state", 32'(state), 32'd0);
    reset_n = 1'b1;
    run_instr("post-reset j", 6'b000010, 6'b000000, 3);

    for (int k = 0; k < 150; k++) begin
      op = ($urandom_range(0, 7) == 0) ? 6'($urandom) : oplist[$urandom_range(0, 5)];
      fn = ($urandom_range(0, 3) == 0) ? 6'($urandom) : fnlist[$urandom_range(0, 4)];
      run_instr($sformatf("rnd%0d op%b fn%b", k, op, fn), op, fn, 2);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
